// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and ID-side handshake bundle for the instruction fetch queue.
// The queue takes the slave view; the fetch/ID environment takes the master view.
interface inst_fetch_queue_if #(
  parameter int LINE_W = 64
);
  logic                  line1_fetch_valid_i;
  logic                  line2_fetch_valid_i;
  logic [2*LINE_W-1:0]   fetch_ibus;
  logic                  fetch_allowin_o;
  logic                  next_allowin_i;
  logic                  line1_now_to_next_valid_o;
  logic                  line2_now_to_next_valid_o;
  logic [2*LINE_W-1:0]   to_next_obus;

  modport master (
    output line1_fetch_valid_i,
    output line2_fetch_valid_i,
    output fetch_ibus,
    input  fetch_allowin_o,
    output next_allowin_i,
    input  line1_now_to_next_valid_o,
    input  line2_now_to_next_valid_o,
    input  to_next_obus
  );

  modport slave (
    input  line1_fetch_valid_i,
    input  line2_fetch_valid_i,
    input  fetch_ibus,
    output fetch_allowin_o,
    input  next_allowin_i,
    output line1_now_to_next_valid_o,
    output line2_now_to_next_valid_o,
    output to_next_obus
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Dual-line circular instruction buffer between fetch and ID.
// Two lines in and up to two lines out per cycle; whole-queue flush.
module inst_fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int LINE_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     excep_flush_i,
  input  logic                     branch_flush_i,
  inst_fetch_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_nx, wptr_l2;
  logic [CW-1:0]     count_q, count_d;

  logic              flush;
  logic              allowin;
  logic              enq;
  logic              l1v, l2v;
  logic              v1, v2;
  logic [1:0]        n_in, n_out;
  logic [LINE_W-1:0] in_l1, in_l2;

  assign flush   = excep_flush_i | branch_flush_i;
  // Credit comes only from the registered count; dequeues don't help.
  assign allowin = count_q <= CW'(DEPTH - 2);
  assign enq     = allowin & ~flush;
  assign l1v     = bus.line1_fetch_valid_i;
  assign l2v     = bus.line2_fetch_valid_i;
  assign in_l1   = bus.fetch_ibus[LINE_W-1:0];
  assign in_l2   = bus.fetch_ibus[2*LINE_W-1:LINE_W];

  assign v1 = (count_q != '0) & ~flush;
  assign v2 = (count_q >= CW'(2)) & ~flush;

  assign rptr_nx = rptr_q + {{(AW-1){1'b0}}, 1'b1};
  // A lone line2 is compacted into the line1 slot.
  assign wptr_l2 = wptr_q + {{(AW-1){1'b0}}, l1v};

  always_comb begin
    n_in    = enq ? ({1'b0, l1v} + {1'b0, l2v}) : 2'd0;
    n_out   = (bus.next_allowin_i & ~flush) ? ({1'b0, v1} + {1'b0, v2}) : 2'd0;
    rptr_d  = rptr_q + AW'(n_out);
    wptr_d  = wptr_q + AW'(n_in);
    count_d = count_q + CW'(n_in) - CW'(n_out);
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (enq & l1v) mem_q[wptr_q]  <= in_l1;
      if (enq & l2v) mem_q[wptr_l2] <= in_l2;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  assign bus.fetch_allowin_o           = allowin;
  assign bus.line1_now_to_next_valid_o = v1;
  assign bus.line2_now_to_next_valid_o = v2;
  assign bus.to_next_obus              = {mem_q[rptr_nx], mem_q[rptr_q]};
  assign count_o                       = count_q;
endmodule
